esc_pwm_generator: RTL
======================

// Module: esc_pwm_generator
// PURPOSE
//  Consumes the 8-bit duty value (0x00..0x64 = 0..100 %) produced by the motor offset summer, one per motor.
//  Emits one ESC PWM waveform per motor channel. Frame = 100 duty steps.
//  Duty is latched once per frame, so a frame never glitches. Out-of-range duty is clamped.
//  When disarmed, the ESC idle duty (50 %) is forced.
// PARAMETERS
//  PRESCALE    2000  clk cycles per duty step (frame = 100*PRESCALE cycles); legal range >= 1
//  IDLE_DUTY   8'd50 duty forced while arm=0, and the reset value of the latched duty
//  SLEW_STEP   8'd5  max |change| of the latched duty per frame; used only with ESC_PWM_SLEW_LIMIT_EN
// PORTS
//  clk           in   1  single system clock; all logic on posedge
//  rst_n         in   1  reset: synchronous, active-low
//  duty_in       in   8  requested duty in %; values > 100 are clamped to 100
//  arm           in   1  1 = follow duty_in; 0 = force IDLE_DUTY
//  pwm_out       out  1  PWM to ESC, registered
//  frame_start   out  1  one-cycle pulse on the cycle the new frame's duty is latched
//  duty_clamped  out  1  high for the whole frame whose latched request was > 100
//  duty_active   out  8  currently latched duty (debug/telemetry)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pre_cnt=0, step_cnt=0, duty_q=IDLE_DUTY, pwm_out=0,
//   frame_start=0, duty_clamped=0. Reset mid-frame aborts the frame; the first frame after reset starts at step 0.
//  Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1, and pre_cnt wraps to 0 on that cycle.
//  Step counter: advances on tick through 0..99. On the tick at 99 it wraps to 0. That wrap cycle is the frame boundary.
//  Frame boundary, same edge:
//   - target = arm ? min(duty_in,100) : IDLE_DUTY
//   - duty_q <= target; duty_clamped <= arm & (duty_in>100)
//   - frame_start <= 1 for exactly one cycle
//  duty_in/arm are sampled only at the frame boundary; changes mid-frame take effect next frame.
//  pwm_out <= (step_cnt < duty_q) every cycle, i.e. 1 cycle after the counter.
//   duty_q=0 -> constantly 0; duty_q=100 -> constantly 1; duty_q=N -> high N*PRESCALE cycles per frame.
//  Clamp is compared unsigned 8-bit: 0x65..0xFF -> 100. The upstream sum wrapping past 255 is the upstream's concern.
//  Simultaneous arm fall and large duty_in at the boundary: the arm=0 result (IDLE_DUTY) wins.
//  Frame length is exactly 100*PRESCALE cycles, with no drift.
// CONFIGURATION
//  `ESC_PWM_SLEW_LIMIT_EN defined: while arm=1, at each boundary duty_q moves toward target by at most SLEW_STEP.
//   Example: 50 -> 100 with SLEW_STEP=5 takes 10 frames.
//   Arm=0 bypasses the slew limit: duty_q = IDLE_DUTY immediately (safety).
//   duty_clamped still reflects the raw request.
//  Not defined: duty_q = target directly. SLEW_STEP is unused.
// STRUCTURE
//  Package esc_pwm_pkg:
//   - DUTY_MAX=8'd100, STEPS_PER_FRAME=7'd100, DEFAULT_IDLE_DUTY=8'd50
//   - function clamp_duty(8b)->8b
//  Sub-module pwm_tick_divider (PARAMETER PRESCALE; clk, rst_n -> tick): natural split, reusable elsewhere.
//  This module holds the step counter, duty latch/slew, compare register and flags. One instance per motor.
// TESTING (bench PRESCALE=2, frame=200 clk, IDLE_DUTY=50)
//  1 reset: rst_n=0 for 3 cycles mid-frame, then release -> all outputs 0 and duty_active=50.
//    First frame_start 200 cycles after release. pwm_out high 100 of each 200 cycles.
//  2 duty: arm=1, duty_in=25 -> after the next frame_start, pwm_out high 50 cycles, low 150, period 200.
//  3 extremes: duty_in=0 -> pwm_out never high. duty_in=100 -> constantly high. duty_in=0xC8 -> constantly high with duty_clamped=1.
//  4 mid-frame change: duty_in 20->80 at step 40 -> current frame stays 40 high-cycles; next frame 160.
//  5 disarm: arm=1,duty 90, then arm=0 -> next frame duty_active=50.
//    Same result with slew enabled (no ramp).
//  6 slew (ESC_PWM_SLEW_LIMIT_EN, SLEW_STEP=5): duty_in 50->100 -> duty_active 55,60..100 over 10 frames.
//    100->0 ramps down 5 per frame.

Source files
------------

// File: rtl/esc_pwm_generator_pkg.sv
// ----------------------------------------------------------------------------
// esc_pwm_pkg
// Shared constants and helpers for the ESC PWM generator slice.
//   DUTY_MAX          : largest legal duty request (100 %)
//   STEPS_PER_FRAME   : duty steps making up one PWM frame
//   DEFAULT_IDLE_DUTY : ESC idle/neutral duty used while disarmed
//   clamp_duty()      : saturates an unsigned 8-bit request to DUTY_MAX
// ----------------------------------------------------------------------------
package esc_pwm_pkg;

   typedef logic [7:0] duty_t;
   typedef logic [6:0] step_t;

   localparam duty_t DUTY_MAX          = 8'd100;
   localparam step_t STEPS_PER_FRAME   = 7'd100;
   localparam duty_t DEFAULT_IDLE_DUTY = 8'd50;

   // Requests are plain unsigned bytes, so anything from 0x65 to 0xFF
   // saturates to full duty.
   function automatic duty_t clamp_duty(input duty_t duty);
      return (duty > DUTY_MAX) ? DUTY_MAX : duty;
   endfunction

endpackage

// File: rtl/esc_pwm_generator_if.sv
// ----------------------------------------------------------------------------
// esc_pwm_if
// Per-motor connection between the duty source and the PWM generator.
//   duty_in      : requested duty in % (master -> slave)
//   arm          : 1 = follow duty_in, 0 = force idle duty (master -> slave)
//   pwm_out      : registered PWM waveform to the ESC (slave -> master)
//   frame_start  : one-cycle pulse when a new frame's duty is latched
//   duty_clamped : high for the whole frame whose request exceeded 100
//   duty_active  : duty latched for the current frame (telemetry)
// The master modport belongs to the duty source, the slave modport to the
// generator.
// ----------------------------------------------------------------------------
interface esc_pwm_if;
   import esc_pwm_pkg::*;

   duty_t duty_in;
   logic  arm;
   logic  pwm_out;
   logic  frame_start;
   logic  duty_clamped;
   duty_t duty_active;

   modport master (
      output duty_in,
      output arm,
      input  pwm_out,
      input  frame_start,
      input  duty_clamped,
      input  duty_active
   );

   modport slave (
      input  duty_in,
      input  arm,
      output pwm_out,
      output frame_start,
      output duty_clamped,
      output duty_active
   );

endinterface

// File: rtl/esc_pwm_generator_tick.sv
// ----------------------------------------------------------------------------
// pwm_tick_divider
// Free-running prescaler producing one tick every PRESCALE clock cycles.
//   PRESCALE : clock cycles per tick, must be >= 1
//   clk      : system clock, all logic on posedge
//   rst_n    : synchronous active-low reset
//   tick     : high on the last cycle of each prescale period
// ----------------------------------------------------------------------------
module pwm_tick_divider #(
   parameter int PRESCALE = 2000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] pre_cnt;

   // The tick cycle is also the wrap cycle, so the period is exactly
   // PRESCALE cycles with no dead cycle between periods. With PRESCALE=1
   // the counter sits at zero and tick is permanently high.
   assign tick = (pre_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/esc_pwm_generator.sv
// ----------------------------------------------------------------------------
// esc_pwm_generator
// One ESC PWM channel: a frame of 100 duty steps, duty latched once per
// frame so the waveform never glitches, out-of-range requests clamped and
// the idle duty forced while disarmed.
//   PRESCALE  : clk cycles per duty step (frame = 100*PRESCALE cycles)
//   IDLE_DUTY : duty while disarmed and after reset
//   SLEW_STEP : max duty change per frame when slew limiting is built in
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   bus       : esc_pwm_if slave (duty_in, arm -> pwm_out, frame_start,
//               duty_clamped, duty_active)
// Build option: define ESC_PWM_SLEW_LIMIT_EN to rate-limit the latched duty
// while armed; disarming always jumps straight to IDLE_DUTY.
// ----------------------------------------------------------------------------
module esc_pwm_generator
   import esc_pwm_pkg::*;
#(
   parameter int    PRESCALE  = 2000,
   parameter duty_t IDLE_DUTY = DEFAULT_IDLE_DUTY,
   parameter duty_t SLEW_STEP = 8'd5
) (
   input  logic       clk,
   input  logic       rst_n,
   esc_pwm_if.slave   bus
);

   localparam step_t LAST_STEP = STEPS_PER_FRAME - 7'd1;

   logic  tick;
   logic  frame_end;
   logic  req_over;
   step_t step_cnt;
   duty_t duty_q;
   duty_t target;
   duty_t duty_next;
   logic  pwm_q;
   logic  frame_start_q;
   logic  clamped_q;

   pwm_tick_divider #(
      .PRESCALE (PRESCALE)
   ) u_tick_divider (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // The tick that wraps the step counter is the frame boundary.
   assign frame_end = tick && (step_cnt == LAST_STEP);

   // Work out the duty to latch at the next boundary. Disarm takes
   // priority over any request, however large.
`ifdef ESC_PWM_SLEW_LIMIT_EN
   duty_t diff;

   always_comb begin
      req_over  = (bus.duty_in > DUTY_MAX);
      target    = bus.arm ? clamp_duty(bus.duty_in) : IDLE_DUTY;
      duty_next = target;
      diff      = '0;
      if (bus.arm) begin
         if (target > duty_q) begin
            diff = target - duty_q;
            if (diff > SLEW_STEP) begin
               duty_next = duty_q + SLEW_STEP;
            end
         end else begin
            diff = duty_q - target;
            if (diff > SLEW_STEP) begin
               duty_next = duty_q - SLEW_STEP;
            end
         end
      end
   end
`else
   always_comb begin
      req_over  = (bus.duty_in > DUTY_MAX);
      target    = bus.arm ? clamp_duty(bus.duty_in) : IDLE_DUTY;
      duty_next = target;
   end
`endif

   // Step counter, per-frame duty latch, flags and the compare register.
   // pwm_out compares the pre-edge counter, so it trails the step count
   // by one cycle but keeps exactly duty*PRESCALE high cycles per frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_cnt      <= '0;
         duty_q        <= IDLE_DUTY;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
         clamped_q     <= 1'b0;
      end else begin
         if (tick) begin
            step_cnt <= frame_end ? 7'd0 : step_cnt + 7'd1;
         end
         frame_start_q <= frame_end;
         if (frame_end) begin
            duty_q    <= duty_next;
            clamped_q <= bus.arm & req_over;
         end
         pwm_q <= ({1'b0, step_cnt} < duty_q);
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.frame_start  = frame_start_q;
   assign bus.duty_clamped = clamped_q;
   assign bus.duty_active  = duty_q;

endmodule
